// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//   Next-state sequencer for the ARMSIM control unit. It holds the current
//   control state and each clock picks the next state from one of these:
//   increment, microinstruction jump target, the instruction encoder's
//   decode state, or the fetch state. It stalls on the memory handshake
//   (mfc) and counts entries into the fetch state.
//
//   Optional feature: define ARMSIM_SEQ_WATCHDOG_EN to add an mfc watchdog.
//   A WAIT that sees no mfc for TIMEOUT+1 cycles is forced to ABORT_STATE,
//   and abort pulses for one cycle. Without the macro, WAIT holds
//   indefinitely and abort is tied low.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset_n     in   1   synchronous reset, active-low
//   encoder_in  in   SW  decode state from the instruction encoder
//   ns_ctrl     in   3   next-state select from the current microinstruction
//   cr_addr     in   SW  jump target from the current microinstruction
//   cond_sel    in   2   condition source: 00 mfc, 01 cond_pass, 10 ~halt, 11 1
//   inv         in   1   inverts the selected condition
//   mfc         in   1   memory function complete
//   cond_pass   in   1   ARM condition-code check passed for the current IR
//   halt        in   1   freeze sequencer
//   state_out   out  SW  current control state (registered)
//   wait_mem    out  1   combinational; high while WAIT is awaiting mfc
//   abort       out  1   registered one-cycle pulse on watchdog abort
//   fetch_cnt   out  16  number of entries into FETCH_STATE
//
// Handshake: mfc is a level qualifier sampled at each rising edge while
// ns_ctrl is WAIT. The sequencer leaves WAIT on the first edge where mfc=1,
// so an mfc already high on entry gives a one-cycle WAIT. No ready is
// returned; wait_mem is the stall indication.
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
   parameter int            SW          = 7,
   parameter logic [SW-1:0] RESET_STATE = 7'd0,
   parameter logic [SW-1:0] FETCH_STATE = 7'd1,
   parameter logic [SW-1:0] ABORT_STATE = 7'd127,
   parameter int            TIMEOUT     = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [SW-1:0] encoder_in,
   input  logic [2:0]    ns_ctrl,
   input  logic [SW-1:0] cr_addr,
   input  logic [1:0]    cond_sel,
   input  logic          inv,
   input  logic          mfc,
   input  logic          cond_pass,
   input  logic          halt,
   output logic [SW-1:0] state_out,
   output logic          wait_mem,
   output logic          abort,
   output logic [15:0]   fetch_cnt
);

   typedef enum logic [2:0] {
      NS_INC    = 3'b000,
      NS_JUMP   = 3'b001,
      NS_DECODE = 3'b010,
      NS_CJUMP  = 3'b011,
      NS_WAIT   = 3'b100,
      NS_FETCH  = 3'b101
   } ns_op_e;

   localparam logic [3:0] TIMEOUT_V = 4'(TIMEOUT);

   ns_op_e        ns_op;
   logic [SW-1:0] state_q;
   logic [SW-1:0] state_inc;
   logic [SW-1:0] next_state;
   logic [15:0]   fetch_q;
   logic          cond_raw;
   logic          cond;
   logic          fetch_inc;

   assign ns_op     = ns_op_e'(ns_ctrl);
   assign state_inc = state_q + 1'b1;   // wraps modulo 2^SW
   assign state_out = state_q;
   assign fetch_cnt = fetch_q;
   assign wait_mem  = (ns_op == NS_WAIT) && !mfc;

   always_comb begin
      cond_raw = 1'b1;
      case (cond_sel)
         2'b00:   cond_raw = mfc;
         2'b01:   cond_raw = cond_pass;
         2'b10:   cond_raw = ~halt;
         default: cond_raw = 1'b1;
      endcase
   end

   assign cond = cond_raw ^ inv;

`ifdef ARMSIM_SEQ_WATCHDOG_EN
   logic [3:0] wd_q;
   logic [3:0] wd_next;
   logic       abort_q;
   logic       abort_next;

   assign abort = abort_q;
`else
   logic unused_wd_cfg;

   assign abort         = 1'b0;
   assign unused_wd_cfg = ^{ABORT_STATE, TIMEOUT_V};
`endif

   // Next-state selection; the watchdog override is applied last so it
   // outranks ns_ctrl.
   always_comb begin
      next_state = FETCH_STATE;
      case (ns_op)
         NS_INC:    next_state = state_inc;
         NS_JUMP:   next_state = cr_addr;
         // A failed condition skips the instruction, and an all-zero IR is
         // treated as a no-op. Both return to fetch.
         NS_DECODE: next_state = (!cond_pass || encoder_in == '0) ? FETCH_STATE
                                                                   : encoder_in;
         NS_CJUMP:  next_state = cond ? cr_addr : state_inc;
         NS_WAIT:   next_state = mfc ? state_inc : state_q;
         NS_FETCH:  next_state = FETCH_STATE;
         default:   next_state = FETCH_STATE;
      endcase

`ifdef ARMSIM_SEQ_WATCHDOG_EN
      wd_next    = '0;
      abort_next = 1'b0;
      if (ns_op == NS_WAIT && !mfc) begin
         if (wd_q == TIMEOUT_V) begin
            next_state = ABORT_STATE;
            abort_next = 1'b1;
         end else begin
            wd_next = wd_q + 4'd1;
         end
      end
`endif

      // A stay in FETCH_STATE counts only when it is an explicit jump back
      // into fetch. A WAIT that holds in fetch does not count.
      fetch_inc = ((next_state == FETCH_STATE) && (state_q != FETCH_STATE)) ||
                  ((state_q == FETCH_STATE) && (ns_op == NS_JUMP) &&
                   (cr_addr == FETCH_STATE));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= RESET_STATE;
         fetch_q <= '0;
      end else if (!halt) begin
         state_q <= next_state;
         if (fetch_inc) begin
            fetch_q <= fetch_q + 16'd1;
         end
      end
   end

`ifdef ARMSIM_SEQ_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_q    <= '0;
         abort_q <= 1'b0;
      end else if (halt) begin
         abort_q <= 1'b0;
      end else begin
         wd_q    <= wd_next;
         abort_q <= abort_next;
      end
   end
`endif

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Next-state sequencer for the ARMSIM control unit.
- Holds the 7-bit current control state and selects the next state each clock from one of four sources: increment, microinstruction jump target, the instruction encoder's 7-bit state, or the fetch state.
- Stalls on memory handshake (MFC) and counts fetched instructions.
- Sits between the instruction encoder, the microstore ROM (which supplies the next-state controls) and the memory interface.

Parameters:
- SW, 7, state width; matches encoder output width.
- RESET_STATE, 7'd0, state entered on reset.
- FETCH_STATE, 7'd1, first state of the instruction fetch sequence.
- ABORT_STATE, 7'd127, memory-abort handler state (WATCHDOG_EN only).
- TIMEOUT, 15, maximum MFC wait cycles before abort (WATCHDOG_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous reset, active-low.
- encoder_in  input  SW  decode state from the instruction encoder.
- ns_ctrl  input  3  next-state select from the current microinstruction.
- cr_addr  input  SW  jump target from the current microinstruction.
- cond_sel  input  2  condition source: 00 mfc, 01 cond_pass, 10 ~halt, 11 constant 1.
- inv  input  1  inverts the selected condition.
- mfc  input  1  memory function complete.
- cond_pass  input  1  ARM condition-code check passed for the current IR.
- halt  input  1  freeze sequencer.
- state_out  output  SW  current control state, registered.
- wait_mem  output  1  combinational; high while held in WAIT awaiting mfc.
- abort  output  1  registered one-cycle pulse on watchdog abort.
- fetch_cnt  output  16  number of entries into FETCH_STATE.

Behaviour:
- All state updates occur on the rising clk edge.
- Priority, highest first: reset, halt, watchdog, ns_ctrl.
- Reset (reset_n=0 at the edge): state_out=RESET_STATE, abort=0, fetch_cnt=0, watchdog counter=0.
  - Reset overrides everything, including mid-WAIT.
  - First post-reset state: set by microstore, normally JUMP to FETCH_STATE.
- Halt (halt=1): state_out, fetch_cnt and the watchdog counter hold; abort=0. wait_mem still reflects the held state.
- c = selected condition XOR inv.
- ns_ctrl encodings:
  - 000 INC: next = state_out+1, modulo 2^SW (127 wraps to 0).
  - 001 JUMP: next = cr_addr.
  - 010 DECODE: next = encoder_in. Exceptions: cond_pass=0 gives FETCH_STATE (instruction skipped); encoder_in=0 (all-zero IR) gives FETCH_STATE. The cond_pass=0 rule takes precedence.
  - 011 CJUMP: next = c ? cr_addr : state_out+1.
  - 100 WAIT: next = mfc ? state_out+1 : state_out. wait_mem = ~mfc.
  - 101 FETCH: next = FETCH_STATE.
  - 110, 111 reserved: next = FETCH_STATE.
- Latency: one cycle from control inputs to state_out; no bypass.
- fetch_cnt: +1 on every edge where the next state is FETCH_STATE and the current state is not FETCH_STATE, or the current state equals FETCH_STATE under JUMP to FETCH_STATE. A stay in FETCH_STATE under WAIT does not count. Wraps 65535 to 0 silently.
- mfc arriving in the same cycle WAIT is entered: leaves on the next edge, so WAIT lasts a minimum of one cycle.
- wait_mem is low in any state whose ns_ctrl is not 100.

Optional Feature:
- Macro: ARMSIM_SEQ_WATCHDOG_EN.
- Defined:
  - A 4-bit counter increments each cycle spent in WAIT with mfc=0.
  - It clears on leaving WAIT, on mfc=1, or on reset.
  - When the counter equals TIMEOUT and mfc=0, next = ABORT_STATE, abort=1 for exactly that following cycle, and the counter clears.
  - mfc=1 in the same cycle as the timeout wins: normal INC, no abort.
- Undefined: counter absent, abort tied 0, WAIT holds indefinitely.

Test Plan:
1. Reset/fetch: reset_n=0 for 2 cycles, then ns_ctrl=001 with cr_addr=1 → state_out=0 during reset, then 1; fetch_cnt=1.
2. Decode: state 5, ns_ctrl=010, encoder_in=7'b0101100, cond_pass=1 → state_out=44 next cycle. Same with cond_pass=0 → state_out=1, fetch_cnt increments. Same with encoder_in=0, cond_pass=1 → state_out=1.
3. Memory wait: ns_ctrl=100, mfc=0 for 3 cycles then 1 → state_out held for 4 cycles with wait_mem=1 for the first 3, then state+1 and wait_mem=0.
4. Conditional and wrap: CJUMP with cond_sel=11, inv=1 at state 127 → state_out=0. CJUMP with cond_sel=01, cond_pass=1, cr_addr=40 → state_out=40.
5. Halt/reset mid-op: halt=1 during WAIT for 5 cycles → state_out and fetch_cnt frozen. reset_n=0 during WAIT → state_out=0, wait_mem low once ns_ctrl is no longer WAIT.
6. Watchdog (macro defined): WAIT with mfc=0 for 16 cycles → state_out=127, abort high for 1 cycle. Repeat with mfc=1 on cycle 16 → INC, abort=0.
